seq_mult: RTL and testbench

//  Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per clock.

---
 rtl/seq_mult_pkg.sv | 15 +
 rtl/seq_mult_step.sv | 21 ++
 rtl/seq_mult.sv | 117 +++++++++++
 tb/tb_seq_mult.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } seq_mult_state_t;

    // Counter must be able to hold WIDTH itself (the finishing CALC step).
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: adds the multiplicand, shifted by the bit index,
// into the accumulator when the current multiplier bit is set.
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_mplr_bit,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [2*WIDTH-1:0] w_mcand_ext;

    assign w_mcand_ext = {{WIDTH{1'b0}}, i_mcand};
    assign o_acc_next  = i_mplr_bit ? (i_acc + (w_mcand_ext << i_cnt)) : i_acc;

endmodule

// File: rtl/seq_mult.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier with valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN to honour the Signed input (two's-complement operands).
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    input  logic               Signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Product
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = cnt_w(WIDTH);

    seq_mult_state_t    r_state, w_state_next;
    logic [PROD_W-1:0]  r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;

    logic [PROD_W-1:0]  w_acc_next;
    logic [WIDTH-1:0]   w_mcand_mag;
    logic [WIDTH-1:0]   w_mplr_mag;
    logic               w_sign;
    logic               w_accept;
    logic               w_cnt_done;

`ifdef SEQ_MULT_SIGNED_EN
    logic w_neg_a, w_neg_b;

    // Magnitude of the most-negative value still fits in WIDTH unsigned bits.
    assign w_neg_a     = Signed & Multiplicand[WIDTH-1];
    assign w_neg_b     = Signed & Multiplier[WIDTH-1];
    assign w_mcand_mag = w_neg_a ? -Multiplicand : Multiplicand;
    assign w_mplr_mag  = w_neg_b ? -Multiplier : Multiplier;
    assign w_sign      = w_neg_a ^ w_neg_b;
`else
    logic w_unused_signed;

    assign w_unused_signed = Signed;
    assign w_mcand_mag     = Multiplicand;
    assign w_mplr_mag      = Multiplier;
    assign w_sign          = 1'b0;
`endif

    assign in_ready   = (r_state == IDLE) && !rst;
    assign out_valid  = (r_state == DONE);
    assign Product    = r_acc;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_done = (r_cnt == CNT_W'(WIDTH));

    seq_mult_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .i_acc      (r_acc),
        .i_mcand    (r_mcand),
        .i_mplr_bit (r_mplr[0]),
        .i_cnt      (r_cnt),
        .o_acc_next (w_acc_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = CALC;
            CALC:    if (w_cnt_done) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= w_mcand_mag;
                        r_mplr  <= w_mplr_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= w_sign;
                    end
                end
                CALC: begin
                    // Final CALC step applies the sign while entering DONE.
                    if (w_cnt_done) begin
                        r_acc <= r_neg ? -r_acc : r_acc;
                    end else begin
                        r_acc  <= w_acc_next;
                        r_mplr <= r_mplr >> 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: directed WIDTH=4 cases plus WIDTH=16 random run.
module tb_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // WIDTH=4 instance
    logic       rst4 = 1'b1, in_valid4 = 1'b0, in_ready4, S4 = 1'b0, out_valid4, rdy4 = 1'b1;
    logic [3:0] A4 = '0, B4 = '0;
    logic [7:0] Product4;

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .Multiplicand(A4), .Multiplier(B4), .Signed(S4),
        .out_valid(out_valid4), .out_ready(rdy4), .Product(Product4)
    );

    // WIDTH=16 instance
    logic        rst16 = 1'b1, in_valid16 = 1'b0, in_ready16, out_valid16, rdy16 = 1'b1;
    logic [15:0] A16 = '0, B16 = '0;
    logic [31:0] Product16;

    seq_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
        .Multiplicand(A16), .Multiplier(B16), .Signed(1'b0),
        .out_valid(out_valid16), .out_ready(rdy16), .Product(Product16)
    );

    logic [7:0]  q4_prod[$];
    int          q4_cyc[$];
    logic [31:0] q16_prod[$];
    int          q16_cyc[$];

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic signed [7:0] sa, sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
`ifdef SEQ_MULT_SIGNED_EN
        if (s) return sa * sb;
`else
        if (s && (sa == sb) && 1'b0) return '0;
`endif
        return {4'b0, a} * {4'b0, b};
    endfunction

    // Output monitors: latency on out_valid rise, product on handshake.
    logic prev4 = 1'b0, prev16 = 1'b0;

    always @(negedge clk) begin
        if (out_valid4 && !prev4) begin
            if (q4_cyc.size() == 0) check("unexpected_valid4", 1, 0);
            else                    check("latency4", cyc - q4_cyc[0], 5);
        end
        if (out_valid4 && rdy4) begin
            if (q4_prod.size() == 0) check("empty_q4", 1, 0);
            else begin
                check("prod4", Product4, q4_prod.pop_front());
                void'(q4_cyc.pop_front());
            end
        end
        prev4 = out_valid4;
    end

    always @(negedge clk) begin
        if (out_valid16 && !prev16) begin
            if (q16_cyc.size() == 0) check("unexpected_valid16", 1, 0);
            else                     check("latency16", cyc - q16_cyc[0], 17);
        end
        if (out_valid16 && rdy16) begin
            if (q16_prod.size() == 0) check("empty_q16", 1, 0);
            else begin
                check("prod16", Product16, q16_prod.pop_front());
                void'(q16_cyc.pop_front());
            end
        end
        prev16 = out_valid16;
    end

    // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic push);
        int guard;
        in_valid4 = 1'b1; A4 = a; B4 = b; S4 = s;
        guard = 0;
        forever begin
            @(negedge clk);
            if (in_ready4) break;
            guard++;
            if (guard > 100) begin
                check("timeout_in_ready4", 0, 1);
                in_valid4 = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        if (push) begin
            q4_prod.push_back(model4(a, b, s));
            q4_cyc.push_back(cyc);
        end
        in_valid4 = 1'b0;
        A4 = 4'($urandom); B4 = 4'($urandom); S4 = 1'($urandom);
    endtask

    task automatic wait_idle4();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (q4_prod.size() == 0 && !out_valid4) break;
            guard++;
            if (guard > 200) begin
                check("timeout_idle4", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run4();
        int guard;
        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready4, 0);
        check("rst_out_valid", out_valid4, 0);
        check("rst_product", Product4, 0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready4, 1);
        @(posedge clk); #1;

        drive4(4'd15, 4'd15, 1'b0, 1'b1);
        wait_idle4();

        drive4(4'd0, 4'd9, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy_in_ready", in_ready4, 0);
        end
        wait_idle4();
        drive4(4'd9, 4'd0, 1'b0, 1'b1);
        wait_idle4();

        // Backpressure
        rdy4 = 1'b0;
        drive4(4'd7, 4'd6, 1'b0, 1'b1);
        guard = 0;
        forever begin
            @(negedge clk);
            if (out_valid4) break;
            guard++;
            if (guard > 50) begin
                check("timeout_valid4", 0, 1);
                break;
            end
        end
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid4, 1);
            check("hold_product", Product4, 8'd42);
        end
        @(posedge clk); #1;
        rdy4 = 1'b1;
        @(posedge clk); #1;
        rdy4 = 1'b0;
        @(negedge clk);
        check("after_hs_in_ready", in_ready4, 1);
        check("after_hs_valid", out_valid4, 0);
        @(posedge clk); #1;
        rdy4 = 1'b1;

        // Abort with reset in second CALC cycle
        drive4(4'd13, 4'd11, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid4, 0);
        check("abort_product", Product4, 0);
        check("abort_in_ready", in_ready4, 1);
        @(posedge clk); #1;
        drive4(4'd3, 4'd5, 1'b0, 1'b1);
        wait_idle4();

        // Signed handling (ignored unless SEQ_MULT_SIGNED_EN)
        drive4(4'h8, 4'h8, 1'b1, 1'b1); wait_idle4();
        drive4(4'hD, 4'h5, 1'b1, 1'b1); wait_idle4();
        drive4(4'h7, 4'hF, 1'b1, 1'b1); wait_idle4();
        drive4(4'hD, 4'h5, 1'b0, 1'b1); wait_idle4();
    endtask

    always @(posedge clk) begin
        #1;
        rdy16 = 1'($urandom_range(0, 1));
    end

    task automatic run16();
        int          guard;
        logic [15:0] a, b;
        @(posedge clk); #1;
        rst16 = 1'b0;
        for (int unsigned n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            in_valid16 = 1'b1; A16 = a; B16 = b;
            guard = 0;
            forever begin
                @(negedge clk);
                if (in_ready16) break;
                guard++;
                if (guard > 200) break;
            end
            if (guard > 200) begin
                check("timeout_in_ready16", 0, 1);
                in_valid16 = 1'b0;
                return;
            end
            @(posedge clk); #1;
            q16_prod.push_back({16'b0, a} * {16'b0, b});
            q16_cyc.push_back(cyc);
            in_valid16 = 1'b0;
            A16 = 16'($urandom); B16 = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        guard = 0;
        while (q16_prod.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("drain16", q16_prod.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        fork
            run4();
            run16();
        join
        check("drain4", q4_prod.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
